// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencing: load-use stalls, taken-branch flushes,
// data-memory valid/ready handshake with timeout, stall/flush counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_mem_read,
  input  logic                  exe_branch_taken,
  input  logic                  mem_req,
  output logic                  dmem_valid,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_exe_en,
  output logic                  exe_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  exe_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  mem_fault,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        load_use;
  logic        decide;
  logic        freeze;
  logic        branch_flush;

  always_comb begin
    load_use = exe_mem_read && (exe_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == exe_rd)) ||
                (id_uses_rs2 && (id_rs2 == exe_rd)));
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    decide        = 1'b0;
    freeze        = 1'b0;
    branch_flush  = 1'b0;
    dmem_valid    = 1'b0;
    mem_fault     = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_exe_en     = 1'b0;
    exe_mem_en    = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_flush  = 1'b0;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (mem_req) begin
            dmem_valid = 1'b1;
            if (!dmem_ready) begin
              freeze  = 1'b1;
              state_d = MEM_WAIT;
              timer_d = '0;
            end else begin
              decide = 1'b1;
            end
          end else begin
            decide = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_valid = 1'b1;
          if (dmem_ready) begin
            decide  = 1'b1;
            state_d = RUN;
          end else if (timer_q == 8'(MEM_TIMEOUT - 1)) begin
            // Abort: let the pipeline advance but squash the faulting instruction.
            mem_fault    = 1'b1;
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_exe_en    = 1'b1;
            exe_mem_en   = 1'b1;
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = RUN;
          end else begin
            freeze  = 1'b1;
            timer_d = timer_q + 8'd1;
          end
        end
        default: state_d = RUN;
      endcase

      if (freeze) begin
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b1;
      end

      if (decide) begin
        id_exe_en  = 1'b1;
        exe_mem_en = 1'b1;
        mem_wb_en  = 1'b1;
        if (exe_branch_taken) begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          branch_flush = 1'b1;
        end else if (load_use) begin
          id_exe_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (!pc_en) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
